// File: rtl/pipe_perf_counters_pkg.sv
// Event index map for the 5-stage pipeline hazard/control counters.
package pipe_perf_pkg;

    localparam int unsigned EV_STALL      = 0;
    localparam int unsigned EV_BRANCH     = 1;
    localparam int unsigned EV_FWD_A      = 2;
    localparam int unsigned EV_FWD_B      = 3;
    localparam int unsigned EV_FLUSH_IFID = 4;
    localparam int unsigned EV_FLUSH_IDEX = 5;
    localparam int unsigned EV_RETIRE     = 6;
    localparam int unsigned EV_LOAD_USE   = 7;

    localparam int unsigned NUM_STD_EVENTS = 8;

endpackage

// File: rtl/pipe_perf_counters_if.sv
// Control, event and read-back signals of the counter bank.
interface pipe_perf_counters_if
    import pipe_perf_pkg::*;
#(
    parameter int unsigned NUM_EVENTS = NUM_STD_EVENTS,
    parameter int unsigned CNT_W      = 32
);
    localparam int unsigned SEL_W = $clog2(NUM_EVENTS + 1);

    logic                  en;
    logic [NUM_EVENTS-1:0] events;
    logic                  clear;
    logic                  snap;
    logic [SEL_W-1:0]      rd_sel;
    logic                  rd_live;
    logic [NUM_EVENTS-1:0] irq_mask;
    logic [CNT_W-1:0]      rd_data;
    logic [NUM_EVENTS-1:0] ovf;
    logic                  irq;

    modport master (
        output en, events, clear, snap, rd_sel, rd_live, irq_mask,
        input  rd_data, ovf, irq
    );

    modport slave (
        input  en, events, clear, snap, rd_sel, rd_live, irq_mask,
        output rd_data, ovf, irq
    );

endinterface

// File: rtl/pipe_perf_counters_cell.sv
// One counter: live count, wrap/saturate, sticky overflow, snapshot shadow.
module perf_cnt_cell #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    input  logic             snap,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] shadow,
    output logic             ovf
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             ovf_q, ovf_d;

    // Next state: clear beats increment; snap always sees the pre-edge count.
    always_comb begin
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        shadow_d = shadow_q;
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            if (cnt_q == '1) begin
                ovf_d = 1'b1;
                cnt_d = (SATURATE != 0) ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (snap) begin
            shadow_d = cnt_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign cnt    = cnt_q;
    assign shadow = shadow_q;
    assign ovf    = ovf_q;

endmodule

// File: rtl/pipe_perf_counters.sv
// Pipeline event counter bank: per-event cells, cycle counter, read mux, irq.
module pipe_perf_counters
    import pipe_perf_pkg::*;
#(
    parameter int unsigned NUM_EVENTS = NUM_STD_EVENTS,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned SATURATE   = 0
) (
    input  logic               clk,
    input  logic               rst,
    pipe_perf_counters_if.slave bus
);

    localparam int unsigned SEL_W = $clog2(NUM_EVENTS + 1);

    logic [CNT_W-1:0]      cnt    [NUM_EVENTS];
    logic [CNT_W-1:0]      shadow [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] ovf_vec;
    logic [CNT_W-1:0]      cyc_cnt, cyc_shadow;
    logic                  cyc_ovf_unused;

    logic [CNT_W-1:0]      rd_data_q, rd_data_d;
    logic                  irq_q, irq_d;

    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_cell
        perf_cnt_cell #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .inc    (bus.en & bus.events[g]),
            .clear  (bus.clear),
            .snap   (bus.snap),
            .cnt    (cnt[g]),
            .shadow (shadow[g]),
            .ovf    (ovf_vec[g])
        );
    end

    perf_cnt_cell #(
        .CNT_W    (CNT_W),
        .SATURATE (SATURATE)
    ) u_cycle (
        .clk    (clk),
        .rst    (rst),
        .inc    (bus.en),
        .clear  (bus.clear),
        .snap   (bus.snap),
        .cnt    (cyc_cnt),
        .shadow (cyc_shadow),
        .ovf    (cyc_ovf_unused)
    );

    // Read mux and irq source; selects above the cycle counter return zero.
    always_comb begin
        rd_data_d = '0;
        for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                rd_data_d = bus.rd_live ? cnt[i] : shadow[i];
            end
        end
        if (bus.rd_sel == SEL_W'(NUM_EVENTS)) begin
            rd_data_d = bus.rd_live ? cyc_cnt : cyc_shadow;
        end
        irq_d = bus.clear ? 1'b0 : |(ovf_vec & bus.irq_mask);
    end

    // Registered read data and interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.ovf     = ovf_vec;
    assign bus.irq     = irq_q;

endmodule

// File: tb/tb_pipe_perf_counters.sv
// Directed bench: a wrapping and a saturating 4-bit bank driven in lockstep.
module tb_pipe_perf_counters;
    import pipe_perf_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] events;
    logic       clear;
    logic       snap;
    logic [3:0] rd_sel;
    logic       rd_live;
    logic [7:0] irq_mask;

    int errors = 0;
    int checks = 0;

    pipe_perf_counters_if #(.NUM_EVENTS(8), .CNT_W(4)) bus_w ();
    pipe_perf_counters_if #(.NUM_EVENTS(8), .CNT_W(4)) bus_s ();

    assign bus_w.en = en;         assign bus_s.en = en;
    assign bus_w.events = events; assign bus_s.events = events;
    assign bus_w.clear = clear;   assign bus_s.clear = clear;
    assign bus_w.snap = snap;     assign bus_s.snap = snap;
    assign bus_w.rd_sel = rd_sel; assign bus_s.rd_sel = rd_sel;
    assign bus_w.rd_live = rd_live; assign bus_s.rd_live = rd_live;
    assign bus_w.irq_mask = irq_mask; assign bus_s.irq_mask = irq_mask;

    pipe_perf_counters #(.NUM_EVENTS(8), .CNT_W(4), .SATURATE(0)) u_dut_wrap (
        .clk(clk), .rst(rst), .bus(bus_w)
    );
    pipe_perf_counters #(.NUM_EVENTS(8), .CNT_W(4), .SATURATE(1)) u_dut_sat (
        .clk(clk), .rst(rst), .bus(bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ev;
        logic       en;
        logic       clr;
        logic       snp;
        logic [3:0] sel;
        logic       live;
        logic       chk;
        logic [3:0] exp_w;
        logic [3:0] exp_s;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [7:0] ev, logic e, logic clr, logic snp,
                                logic [3:0] sel, logic live, logic chk,
                                logic [3:0] exp_w, logic [3:0] exp_s, string name);
        vec_t v;
        v.ev = ev; v.en = e; v.clr = clr; v.snp = snp; v.sel = sel; v.live = live;
        v.chk = chk; v.exp_w = exp_w; v.exp_s = exp_s; v.name = name;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_both(string name, logic [3:0] exp_w, logic [3:0] exp_s);
        check({name, "/wrap"}, 32'(bus_w.rd_data), 32'(exp_w));
        check({name, "/sat"},  32'(bus_s.rd_data), 32'(exp_s));
    endtask

    task automatic read(logic [3:0] sel, logic live, string name,
                        logic [3:0] exp_w, logic [3:0] exp_s);
        events = '0; rd_sel = sel; rd_live = live;
        step();
        check_both(name, exp_w, exp_s);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; events = '0; clear = 1'b0; snap = 1'b0;
        rd_sel = '0; rd_live = 1'b1; irq_mask = '0;

        // Idle reads, then stall x3 / branch x1 counting and read latency.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(8'h00, 0, 0, 0, 4'(i), 1, 1, 4'd0, 4'd0, "idle_evt"));
        vecs.push_back(mk(8'h00, 0, 0, 0, 4'd8,  1, 1, 4'd10, 4'd10, "idle_cycle"));
        vecs.push_back(mk(8'h00, 0, 0, 0, 4'd9,  1, 1, 4'd0, 4'd0, "idle_sel9"));
        vecs.push_back(mk(8'h00, 0, 0, 0, 4'd15, 1, 1, 4'd0, 4'd0, "idle_sel15"));
        vecs.push_back(mk(8'h00, 0, 0, 0, 4'd8,  0, 1, 4'd0, 4'd0, "idle_cyc_shadow"));
        vecs.push_back(mk(8'h00, 0, 1, 0, 4'd0,  1, 0, 4'd0, 4'd0, "clr"));
        vecs.push_back(mk(8'h01, 1, 0, 0, 4'd0,  1, 0, 4'd0, 4'd0, "stall1"));
        vecs.push_back(mk(8'h01, 1, 0, 0, 4'd0,  1, 1, 4'd1, 4'd1, "stall2_latency"));
        vecs.push_back(mk(8'h01, 1, 0, 0, 4'd0,  1, 0, 4'd0, 4'd0, "stall3"));
        vecs.push_back(mk(8'h02, 1, 0, 0, 4'd0,  1, 0, 4'd0, 4'd0, "branch"));
        vecs.push_back(mk(8'h00, 0, 0, 0, 4'd0,  1, 1, 4'd3, 4'd3, "rd_stall"));
        vecs.push_back(mk(8'h00, 0, 0, 0, 4'd1,  1, 1, 4'd1, 4'd1, "rd_branch"));
        vecs.push_back(mk(8'h00, 0, 0, 0, 4'd9,  1, 1, 4'd0, 4'd0, "rd_sel9"));
        vecs.push_back(mk(8'h00, 0, 0, 0, 4'd8,  1, 1, 4'd4, 4'd4, "rd_cycle"));

        // Reset state while rst is held.
        #12;
        check_both("reset_rd_data", 4'd0, 4'd0);
        check("reset_ovf", 32'({bus_w.ovf, bus_s.ovf}), 32'd0);
        check("reset_irq", 32'({bus_w.irq, bus_s.irq}), 32'd0);
        step();
        rst = 1'b0; en = 1'b1;
        repeat (10) step();
        en = 1'b0;

        foreach (vecs[i]) begin
            events = vecs[i].ev; en = vecs[i].en; clear = vecs[i].clr;
            snap = vecs[i].snp; rd_sel = vecs[i].sel; rd_live = vecs[i].live;
            step();
            if (vecs[i].chk) check_both(vecs[i].name, vecs[i].exp_w, vecs[i].exp_s);
        end
        clear = 1'b0; en = 1'b0; events = '0;
        check("idle_ovf", 32'({bus_w.ovf, bus_s.ovf}), 32'd0);
        check("idle_irq", 32'({bus_w.irq, bus_s.irq}), 32'd0);

        // Wrap/saturate on EV_FWD_A with its interrupt enabled.
        irq_mask = 8'h04; en = 1'b1; events = 8'h00; events[EV_FWD_A] = 1'b1;
        for (int p = 1; p <= 17; p++) begin
            step();
            if (p == 15) check("fwd_ovf_before_wrap", 32'(bus_w.ovf[2]), 32'd0);
            if (p == 16) begin
                check("fwd_ovf_at_wrap", 32'(bus_w.ovf[2]), 32'd1);
                check("fwd_ovf_at_sat", 32'(bus_s.ovf[2]), 32'd1);
                check("fwd_irq_same_edge", 32'(bus_w.irq), 32'd0);
            end
            if (p == 17) begin
                check("fwd_irq_next_edge/wrap", 32'(bus_w.irq), 32'd1);
                check("fwd_irq_next_edge/sat", 32'(bus_s.irq), 32'd1);
            end
        end
        read(4'(EV_FWD_A), 1'b1, "fwd_count", 4'd1, 4'd15);

        // 20 stall pulses: saturates at 15, wraps 3+20 to 7; then clear.
        irq_mask = 8'h05; events = 8'h01;
        repeat (20) step();
        read(4'd0, 1'b1, "stall20", 4'd7, 4'd15);
        check("stall20_ovf", 32'({bus_w.ovf[0], bus_s.ovf[0]}), 32'd3);
        check("stall20_irq", 32'({bus_w.irq, bus_s.irq}), 32'd3);
        clear = 1'b1; step(); clear = 1'b0;
        check("clear_ovf", 32'({bus_w.ovf, bus_s.ovf}), 32'd0);
        check("clear_irq", 32'({bus_w.irq, bus_s.irq}), 32'd0);
        read(4'd0, 1'b1, "clear_cnt", 4'd0, 4'd0);

        // snap + clear + event together, then snap + event.
        events = 8'h01;
        repeat (5) step();
        snap = 1'b1; clear = 1'b1; step(); snap = 1'b0; clear = 1'b0;
        read(4'd0, 1'b0, "collide_shadow", 4'd5, 4'd5);
        read(4'd0, 1'b1, "collide_live", 4'd0, 4'd0);
        clear = 1'b1; step(); clear = 1'b0;
        read(4'd0, 1'b0, "shadow_after_clear", 4'd5, 4'd5);
        events = 8'h01;
        repeat (2) step();
        snap = 1'b1; step(); snap = 1'b0;
        read(4'd0, 1'b0, "snap_evt_shadow", 4'd2, 4'd2);
        read(4'd0, 1'b1, "snap_evt_live", 4'd3, 4'd3);

        // Async reset between edges with overflow, irq and read data live.
        irq_mask = 8'h08; events = 8'h08;
        repeat (17) step();
        read(4'd3, 1'b1, "pre_rst_read", 4'd1, 4'd15);
        check("pre_rst_irq", 32'({bus_w.irq, bus_s.irq}), 32'd3);
        events = 8'h01; rd_sel = 4'd0; rd_live = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_both("async_rst_rd_data", 4'd0, 4'd0);
        check("async_rst_ovf", 32'({bus_w.ovf, bus_s.ovf}), 32'd0);
        check("async_rst_irq", 32'({bus_w.irq, bus_s.irq}), 32'd0);
        rst = 1'b0;
        step();
        check_both("post_rst_first_read", 4'd0, 4'd0);
        read(4'd0, 1'b1, "post_rst_count", 4'd1, 4'd1);
        read(4'd0, 1'b0, "post_rst_shadow", 4'd0, 4'd0);
        read(4'd3, 1'b1, "post_rst_fwd_b", 4'd0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_perf_counters.md
# pipe_perf_counters

Synthesizable pipeline event counter bank for the 5-stage CPU. It brings the hazard statistics that simulation prints per cycle (stall, branch taken, forwarding, IF/ID and ID/EX flush) into hardware. It counts single-cycle event pulses from the pipeline's hazard and control logic into NUM_EVENTS counters plus a free-running cycle counter. It supports snapshot, clear, wrap or saturate mode, sticky overflow flags and an overflow interrupt. It sits beside the CPU core inside comp, driven by the core's hazard-unit signals.

## Interface
- NUM_EVENTS, 8: number of event counters (1..31).
- CNT_W, 32: counter width in bits (2..64).
- SATURATE, 0: 0 = counters wrap at 2^CNT_W; 1 = counters hold at all-ones.
- SEL_W, derived $clog2(NUM_EVENTS+1): width of the read select.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global count enable; gates event counters and cycle counter.
- events  in  NUM_EVENTS  one pulse per cycle per event; bit i increments counter i.
- clear  in  1  synchronous clear of all counters, ovf flags and irq.
- snap  in  1  copy all live counters and the cycle counter into shadow registers.
- rd_sel  in  SEL_W  0..NUM_EVENTS-1 = event counter; NUM_EVENTS = cycle counter; higher = reads 0.
- rd_live  in  1  1 = read live value; 0 = read shadow value.
- irq_mask  in  NUM_EVENTS  per-counter overflow interrupt enable.
- rd_data  out  CNT_W  registered read data.
- ovf  out  NUM_EVENTS  sticky overflow flags.
- irq  out  1  registered OR of (ovf & irq_mask).

## Operation
- Reset (async): all counters, shadows, ovf, rd_data and irq are set to 0.
- Increment: counter i increments when en & events[i]. The cycle counter increments when en.
- Wrap mode: all-ones + 1 gives 0, and the ovf bit is set in the same edge.
- Saturate mode: an increment at all-ones leaves the counter at all-ones and sets the ovf bit.
- The cycle counter follows the same SATURATE rule but has no ovf flag and no irq.
- ovf bits are sticky until clear or rst.
- Priority per edge: clear beats increment. With clear=1, every counter becomes 0 and every ovf bit becomes 0, even if an event or en is asserted in that cycle.
- snap captures the pre-edge live values, i.e. the values before this edge's increment or clear.
  - snap with clear in the same cycle: shadows get the old values and live counters get 0.
  - snap with an event in the same cycle: the shadow excludes that cycle's event.
- Shadows change only on snap or rst. clear does not alter shadows.
- irq updates one edge after the ovf/irq_mask change and deasserts one edge after clear.

## Timing
- Count latency: an event pulse sampled at edge N is visible in the live counter after edge N.
- Read latency is 1 cycle. rd_data after edge N equals the source selected by rd_sel/rd_live during cycle N, using its pre-edge-N value.
- Changing rd_sel has no side effects, so back-to-back reads on consecutive cycles are permitted.
- No handshake: inputs are sampled every edge, and events is a level sample per cycle (multi-cycle high = multiple counts).
- rst asserted mid-count zeroes all state immediately. The first count occurs at the first edge after rst deasserts.

## Structure
- Package pipe_perf_pkg holds the event index constants:
  - EV_STALL=0, EV_BRANCH=1, EV_FWD_A=2, EV_FWD_B=3
  - EV_FLUSH_IFID=4, EV_FLUSH_IDEX=5, EV_RETIRE=6, EV_LOAD_USE=7
- The top module instantiates one sub-module, perf_cnt_cell, per event counter. Each cell holds:
  - the counter, wrap/saturate logic, sticky ovf and shadow register;
  - parameters CNT_W and SATURATE;
  - ports clk, rst, inc, clear, snap, cnt, shadow, ovf.
- The cycle counter reuses perf_cnt_cell with its ovf output unused.
- The top level holds the read mux, rd_data register and irq register.

## Test plan
- Reset and idle: rst pulse, en=1, events=0 for 10 cycles. Required: all event counters read 0, cycle counter reads 10, ovf=0, irq=0.
- Counting and read latency: EV_STALL high for 3 cycles, EV_BRANCH for 1 cycle, rd_live=1. Required: rd_sel=0 reads 3, rd_sel=1 reads 1, each one cycle after the select. rd_sel=NUM_EVENTS+1 reads 0.
- Wrap overflow (CNT_W=4, SATURATE=0, irq_mask[2]=1): 17 pulses on EV_FWD_A. Required: counter reads 1, ovf[2]=1, irq=1 one edge after the wrap.
- Saturate (CNT_W=4, SATURATE=1): 20 pulses on event 0. Required: counter reads 15 and ovf[0]=1. Then clear → counter 0, ovf 0, irq 0 after one edge.
- Snap/clear collision: counter 0 at 5, then snap+clear+event0 all in the same cycle. Required: shadow 5 (rd_live=0), live 0. A later clear leaves the shadow at 5.
- Async reset mid-run: rst asserted between edges while counters are non-zero. Required: rd_data, ovf, irq and all counters are 0 before the next edge. Counting resumes at the first edge after rst deasserts.
